// File: rtl/data_mem_ctrl.sv
// Single-port data memory with byte strobes, registered reads and a
// zero-fill clear sequencer that runs after reset or a soft clear.
module data_mem_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  req,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  ready,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic                  err,
  output logic                  init_done
);

  localparam int NB    = DATA_W / 8;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  typedef enum logic {INIT, IDLE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    w_ptr_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rvalid;
  logic                r_err;
  logic                r_init_done;

  logic                w_ready;
  logic                w_acc;
  logic                w_inrng;
  logic [PTR_W-1:0]    w_idx;
  logic [NB-1:0]       w_mwe;
  logic [PTR_W-1:0]    w_midx;
  logic [DATA_W-1:0]   w_mdat;

  assign w_ready = (r_state == IDLE) && !clr;
  assign w_acc   = w_ready && req;
  // Full-width compare so high address bits never alias into the array.
  assign w_inrng = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
  assign w_idx   = addr[PTR_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_mwe       = '0;
    w_midx      = r_ptr;
    w_mdat      = '0;
    if (clr) begin
      w_state_nxt = INIT;
      w_ptr_nxt   = '0;
    end else if (r_state == INIT) begin
      w_mwe     = '1;
      w_ptr_nxt = r_ptr + 1'b1;
      if (r_ptr == LAST)
        w_state_nxt = IDLE;
    end else if (w_acc && we && w_inrng) begin
      w_mwe  = be;
      w_midx = w_idx;
      w_mdat = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= INIT;
      r_ptr       <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_err       <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_rvalid <= w_acc && !we;
      r_err    <= w_acc && !w_inrng;
      if (clr) begin
        r_rdata     <= '0;
        r_init_done <= 1'b0;
      end else begin
        if (r_state == INIT && r_ptr == LAST)
          r_init_done <= 1'b1;
        if (w_acc && !we)
          r_rdata <= w_inrng ? r_mem[w_idx] : '0;
      end
    end
  end

  // Storage is left unreset; the clear sequencer gives it a known state.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (w_mwe[i])
        r_mem[w_midx][8*i +: 8] <= w_mdat[8*i +: 8];
  end

  assign ready     = w_ready;
  assign rdata     = r_rdata;
  assign rvalid    = r_rvalid;
  assign err       = r_err;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (DATA_W=16, ADDR_W=16, DEPTH=8).
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        req;
  logic        we;
  logic [1:0]  be;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ready;
  logic [15:0] rdata;
  logic        rvalid;
  logic        err;
  logic        init_done;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .we(we),
    .be(be), .addr(addr), .wdata(wdata), .ready(ready),
    .rdata(rdata), .rvalid(rvalid), .err(err), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req   = 1'b0;
    we    = 1'b0;
    be    = 2'b00;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic access(input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic [1:0] b);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    be    = b;
    step();
  endtask

  task automatic count_init(input string tag);
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++;
      if (ready !== (k == 8)) begin
        n_bad++;
        $display("FAIL %s_ready cyc %0d got %b exp %b", tag, k, ready, k == 8);
      end
    end
    n_cmp++;
    if (init_done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_init_done got %b exp 1", tag, init_done);
    end
  endtask

  task automatic test_reset();
    idle_in();
    clr   = 1'b0;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({ready, rvalid, err, init_done, rdata} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outs got r%b v%b e%b d%b %h exp all 0",
               ready, rvalid, err, init_done, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready0 got %b exp 0", ready);
    end
    count_init("reset");
  endtask

  task automatic test_read_all(input string tag);
    for (int a = 0; a < 8; a++) begin
      access(1'b0, 16'(a), 16'h0, 2'b00);
      n_cmp++;
      if (rvalid !== 1'b1 || rdata !== 16'h0 || err !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_rd%0d got v%b e%b %h exp v1 e0 0000",
                 tag, a, rvalid, err, rdata);
      end
    end
    idle_in();
  endtask

  task automatic test_partial();
    access(1'b1, 16'd3, 16'hABCD, 2'b11);
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL partial_wr_rvalid got %b exp 0", rvalid);
    end
    access(1'b1, 16'd3, 16'h1234, 2'b01);
    access(1'b0, 16'd3, 16'h0, 2'b00);
    n_cmp++;
    if (rdata !== 16'hAB34 || rvalid !== 1'b1) begin
      n_bad++;
      $display("FAIL partial_rd got %h v%b exp ab34 v1", rdata, rvalid);
    end
    idle_in();
    step();
    n_cmp++;
    if (rvalid !== 1'b0 || rdata !== 16'hAB34) begin
      n_bad++;
      $display("FAIL partial_hold got %h v%b exp ab34 v0", rdata, rvalid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [4];
    logic        exp_v [4];
    exp_d = '{16'hAB34, 16'hAB34, 16'h0001, 16'h0002};
    exp_v = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      if (i < 2) access(1'b1, 16'(i), 16'(i + 1), 2'b11);
      else       access(1'b0, 16'(i - 2), 16'h0, 2'b00);
      n_cmp++;
      if (rvalid !== exp_v[i] || err !== 1'b0 ||
          (exp_v[i] && rdata !== exp_d[i])) begin
        n_bad++;
        $display("FAIL b2b_%0d got v%b e%b %h exp v%b e0 %h",
                 i, rvalid, err, rdata, exp_v[i], exp_d[i]);
      end
    end
    idle_in();
  endtask

  task automatic test_out_of_range();
    access(1'b0, 16'd8, 16'h0, 2'b00);
    n_cmp++;
    if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== 16'h0) begin
      n_bad++;
      $display("FAIL oor_rd8 got v%b e%b %h exp v1 e1 0000",
               rvalid, err, rdata);
    end
    access(1'b1, 16'h0108, 16'hFFFF, 2'b11);
    n_cmp++;
    if (rvalid !== 1'b0 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL oor_wr got v%b e%b exp v0 e1", rvalid, err);
    end
    access(1'b0, 16'd0, 16'h0, 2'b00);
    n_cmp++;
    if (rdata !== 16'h0001 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_rd0 got %h e%b exp 0001 e0", rdata, err);
    end
    access(1'b0, 16'd8, 16'h0, 2'b00);
    n_cmp++;
    if (rdata !== 16'h0 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL oor_rd8b got %h e%b exp 0000 e1", rdata, err);
    end
    idle_in();
    step();
    n_cmp++;
    if (rvalid !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_quiet got v%b e%b exp v0 e0", rvalid, err);
    end
  endtask

  task automatic test_soft_clear();
    for (int a = 0; a < 8; a++)
      access(1'b1, 16'(a), 16'(16'h1110 + a), 2'b11);
    access(1'b0, 16'd5, 16'h0, 2'b00);
    n_cmp++;
    if (rdata !== 16'h1115) begin
      n_bad++;
      $display("FAIL clr_fill got %h exp 1115", rdata);
    end
    @(negedge clk);
    clr  = 1'b1;
    req  = 1'b1;
    we   = 1'b0;
    addr = 16'd8;
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_ready_comb got %b exp 0", ready);
    end
    step();
    clr = 1'b0;
    idle_in();
    n_cmp++;
    if (rvalid !== 1'b0 || err !== 1'b0 || rdata !== 16'h0 ||
        init_done !== 1'b0 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_edge got v%b e%b %h d%b r%b exp v0 e0 0000 d0 r0",
               rvalid, err, rdata, init_done, ready);
    end
    count_init("clr");
    test_read_all("clr");
  endtask

  task automatic test_midinit_reset();
    access(1'b1, 16'd6, 16'h5A5A, 2'b11);
    access(1'b0, 16'd6, 16'h0, 2'b00);
    idle_in();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ready, rvalid, err, init_done, rdata} !== 20'h0) begin
      n_bad++;
      $display("FAIL mid_rst got r%b v%b e%b d%b %h exp all 0",
               ready, rvalid, err, init_done, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    count_init("mid");
    test_read_all("mid");
  endtask

  initial begin
    test_reset();
    test_read_all("idle");
    test_partial();
    test_back_to_back();
    test_out_of_range();
    test_soft_clear();
    test_midinit_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised single-port data memory with request/ready handshake, byte-lane write strobes, registered read data and a hardware clear sequencer. It sits between the processor's load/store stage and the data storage array. Compared with a plain array, it adds configurable width and depth, partial-word writes, out-of-range detection and a deterministic zero-initialised state after reset or a soft clear.

## Interface
- DATA_W, 16, data word width in bits; must be a multiple of 8.
- ADDR_W, 16, address bus width.
- DEPTH, 8, number of words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous soft clear; restarts the clear sequence.
- req  input  1  access request.
- we  input  1  1 = write, 0 = read; sampled with req.
- be  input  DATA_W/8  byte-lane write enables; bit i covers data[8i+7:8i]; ignored for reads.
- addr  input  ADDR_W  word address; the full value is compared, so there is no aliasing.
- wdata  input  DATA_W  write data.
- ready  output  1  controller can accept a request this cycle.
- rdata  output  DATA_W  read data, registered.
- rvalid  output  1  one-cycle pulse: rdata holds the result of a read.
- err  output  1  one-cycle pulse: the accepted access had addr ≥ DEPTH.
- init_done  output  1  high once a clear sequence has completed.

## Operation
- States: INIT and IDLE.
- Reset (rst_n low, asynchronous):
  - state = INIT, clear pointer = 0.
  - ready = 0, rvalid = 0, err = 0, rdata = 0, init_done = 0.
- INIT:
  - Each cycle, memory[ptr] is set to 0 and ptr increments.
  - At the edge that clears word DEPTH-1, the block goes to IDLE and sets init_done = 1 and ready = 1.
  - req is ignored while ready = 0.
- IDLE:
  - ready = 1 unless clr is asserted.
  - A request is accepted at an edge where req && ready.
- clr in IDLE:
  - ready drops combinationally.
  - At the edge: state = INIT, ptr = 0, init_done = 0.
  - A req presented in the same cycle is not accepted.
  - clr during INIT restarts the pointer at 0.
- Accepted write, addr < DEPTH:
  - At the accept edge, each byte lane with be[i] = 1 is updated from wdata; other lanes are unchanged.
  - be = 0 is a legal no-op write.
  - No rvalid is generated.
- Accepted read, addr < DEPTH:
  - At the accept edge, rdata ← memory[addr] and rvalid = 1 for one cycle.
- Accepted access with addr ≥ DEPTH:
  - Memory is unchanged.
  - err = 1 for one cycle after the accept edge.
  - A read also gives rvalid = 1 with rdata = 0.
- rdata holds its value until the next completed read, a reset, or a clr edge (clr clears rdata to 0).
- rvalid and err return to 0 in any cycle with no accepted access.

## Timing
- Clear latency: DEPTH cycles from rst_n release (or from the clr edge) to ready = 1.
- Read latency: 1 cycle. The request is accepted at edge N; rdata and rvalid are valid after edge N, during cycle N+1.
- Throughput: one access per cycle, back to back, with no bubbles.
- Write followed by a read of the same address at the next edge returns the new data.
- Reads return the stored value; there is no combinational write-to-read bypass within a single cycle.
- All outputs are registered except ready, which equals (state == IDLE) && !clr.
- rst_n asserted mid-access or mid-INIT aborts immediately. The next clear sequence restarts from word 0.

## Test plan
- Reset, then idle with DEPTH = 8:
  - ready = 0 for 8 cycles after rst_n rises, then ready = 1 and init_done = 1.
  - Reading all 8 addresses gives rdata = 0 with rvalid on each.
- Partial write (DATA_W = 16):
  - Write addr 3 = 0xABCD with be = 2'b11, then write addr 3 = 0x1234 with be = 2'b01.
  - A read of addr 3 one cycle later gives rdata = 0xAB34 and rvalid = 1.
- Back-to-back traffic:
  - Write addr 0 = 0x0001, write addr 1 = 0x0002, read addr 0, read addr 1 on consecutive cycles.
  - rvalid is high in the two cycles after the reads, with rdata = 0x0001 then 0x0002; err stays 0 throughout.
- Out of range:
  - Read addr 8 gives rvalid = 1, err = 1, rdata = 0.
  - Write addr 0x0108 with 0xFFFF gives err = 1 only.
  - Addresses 0 and 8 (mod 8) are unchanged afterwards.
- Soft clear:
  - Fill memory with nonzero data, then pulse clr together with req.
  - The request is not accepted; ready = 0 for 8 cycles; rdata = 0.
  - All subsequent reads return 0.
- Mid-init reset:
  - Assert rst_n low during cycle 4 of INIT.
  - All outputs return to their reset values immediately.
  - After release, ready = 1 exactly 8 cycles later.
